// File: rtl/layer1_maxpool_pkg.sv
// Shared constants, state encoding and rounding helper for the ATCONV layer stages.
package layer1_maxpool_pkg;

    localparam int unsigned IMG_W = 64;  // layer-0 image width/height
    localparam int unsigned DW    = 13;  // unsigned 9.4 fixed point
    localparam int unsigned AW    = 12;  // memory address width
    localparam int unsigned FRAC  = 4;   // fractional bits

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic CSEL_L0 = 1'b0;
    localparam logic CSEL_L1 = 1'b1;

    // Round a fixed-point value up to the next integer. The sum is formed one bit wider
    // than the data so the carry out of the fraction is never lost before truncation.
    function automatic logic [DW-1:0] round_up(input logic [DW-1:0] x,
                                               input int unsigned  frac);
        logic [DW:0] mask;
        logic [DW:0] sum;
        mask = ((DW + 1)'(1) << frac) - (DW + 1)'(1);
        sum  = ({1'b0, x} + mask) & ~mask;
        return sum[DW-1:0];
    endfunction

endpackage

// File: rtl/layer1_maxpool_pool_addr_gen.sv
// Row/column counters for the 2x2 pooling walk; produces window read addresses,
// the layer-1 write address and the end-of-frame flag for the current output pixel.
module layer1_maxpool_pool_addr_gen #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned AW    = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          adv_i,
    input  logic [1:0]    phase_i,
    output logic [AW-1:0] rd_addr_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          last_o
);

    localparam int unsigned OUT_W = IMG_W / 2;
    localparam int unsigned CW    = $clog2(OUT_W);
    localparam logic [CW-1:0] CMAX = CW'(OUT_W - 1);

    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;

    // Next-state for the raster counters: clear on frame start, step after each write.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clr_i) begin
            r_d = '0;
            c_d = '0;
        end else if (adv_i) begin
            if (c_q == CMAX) begin
                c_d = '0;
                r_d = r_q + CW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    // Because IMG_W is a power of two, base + {0,1,IMG_W,IMG_W+1} is a bit concatenation:
    // phase bit 1 selects the lower row, phase bit 0 selects the right column.
    always_comb begin
        rd_addr_o = AW'({r_q, phase_i[1], c_q, phase_i[0]});
        wr_addr_o = AW'({r_q, c_q});
        last_o    = (r_q == CMAX) && (c_q == CMAX);
    end

endmodule

// File: rtl/layer1_maxpool.sv
// Layer-1 2x2 max-pool stage: reads 64x64 layer-0 data, writes ceil(max) of each
// window to layer-1 memory as a 32x32 image, then pulses done.
module layer1_maxpool #(
    parameter int unsigned IMG_W = layer1_maxpool_pkg::IMG_W,
    parameter int unsigned DW    = layer1_maxpool_pkg::DW,
    parameter int unsigned AW    = layer1_maxpool_pkg::AW,
    parameter int unsigned FRAC  = layer1_maxpool_pkg::FRAC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic          csel
);

    import layer1_maxpool_pkg::*;

    state_t        state_q, state_d;
    logic [2:0]    p_q, p_d;
    logic [DW-1:0] max_q, max_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          crd_q, crd_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic          cwr_q, cwr_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic          csel_q, csel_d;

    logic          ag_clr;
    logic          ag_adv;
    logic [AW-1:0] ag_rd_addr;
    logic [AW-1:0] ag_wr_addr;
    logic          ag_last;

    layer1_maxpool_pool_addr_gen #(
        .IMG_W (IMG_W),
        .AW    (AW)
    ) u_pool_addr_gen (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (ag_clr),
        .adv_i     (ag_adv),
        .phase_i   (p_q[1:0]),
        .rd_addr_o (ag_rd_addr),
        .wr_addr_o (ag_wr_addr),
        .last_o    (ag_last)
    );

    // FSM sequencing, phase counter and running window maximum.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        max_d   = max_q;
        ag_clr  = 1'b0;
        ag_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    p_d     = '0;
                    ag_clr  = 1'b1;
                end
            end
            ST_READ: begin
                // Data for the address issued in phase p-1 arrives during phase p;
                // phase 1 loads unconditionally so the previous window never leaks in.
                if (p_q != 3'd0) begin
                    if ((p_q == 3'd1) || (cdata_rd > max_q)) begin
                        max_d = cdata_rd;
                    end
                end
                if (p_q == 3'd4) begin
                    state_d = ST_WRITE;
                    p_d     = '0;
                end else begin
                    p_d = p_q + 3'd1;
                end
            end
            ST_WRITE: begin
                ag_adv  = 1'b1;
                state_d = ag_last ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the current state; address/data buses hold when idle.
    always_comb begin
        crd_d      = (state_q == ST_READ) && (p_q < 3'd4);
        cwr_d      = (state_q == ST_WRITE);
        busy_d     = (state_q == ST_READ) || (state_q == ST_WRITE);
        done_d     = (state_q == ST_DONE);
        caddr_rd_d = crd_d ? ag_rd_addr : caddr_rd_q;
        caddr_wr_d = cwr_d ? ag_wr_addr : caddr_wr_q;
        cdata_wr_d = cwr_d ? round_up(max_q, FRAC) : cdata_wr_q;
        csel_d     = csel_q;
        if (crd_d) begin
            csel_d = CSEL_L0;
        end else if (cwr_d) begin
            csel_d = CSEL_L1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            p_q        <= '0;
            max_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            caddr_rd_q <= '0;
            cwr_q      <= 1'b0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crd      = crd_q;
    assign caddr_rd = caddr_rd_q;
    assign cwr      = cwr_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;

endmodule

// File: tb/tb_layer1_maxpool.sv
// Bench for layer1_maxpool: layer-0 memory model, bus monitor and a pooling reference model.
module tb_layer1_maxpool;

    localparam int unsigned NPIX = 1024;
    localparam int unsigned NRD  = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [12:0] cdata_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [12:0] cdata_wr;
    logic        csel;

    logic [12:0] mem0 [NRD];

    // Layer-0 memory: data for the registered address is available in the following cycle.
    assign cdata_rd = mem0[caddr_rd];

    layer1_maxpool dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    int unsigned edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Bus log, sampled half a cycle after each rising edge.
    int unsigned wr_addr_q[$];
    int unsigned wr_data_q[$];
    int unsigned wr_edge_q[$];
    int unsigned rd_addr_q[$];
    int unsigned rd_edge_q[$];
    int unsigned done_edge_q[$];
    int unsigned busy_cycles = 0;
    int unsigned bad_both = 0;
    int unsigned bad_csel = 0;

    always @(negedge clk) begin
        if (cwr === 1'b1) begin
            wr_addr_q.push_back(32'(caddr_wr));
            wr_data_q.push_back(32'(cdata_wr));
            wr_edge_q.push_back(edge_no);
        end
        if (crd === 1'b1) begin
            rd_addr_q.push_back(32'(caddr_rd));
            rd_edge_q.push_back(edge_no);
        end
        if (done === 1'b1) done_edge_q.push_back(edge_no);
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
        if (crd === 1'b1 && cwr === 1'b1) bad_both <= bad_both + 1;
        if ((crd === 1'b1 && csel !== 1'b0) || (cwr === 1'b1 && csel !== 1'b1))
            bad_csel <= bad_csel + 1;
    end

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned exp_px [NPIX];
    int unsigned got_px [NPIX];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: max of each 2x2 window, rounded up to a multiple of 1.0 (16 in 9.4 format).
    task automatic compute_ref();
        for (int n = 0; n < int'(NPIX); n++) begin
            int unsigned r, c, b, m;
            r = n / 32;
            c = n % 32;
            b = 2 * r * 64 + 2 * c;
            m = mem0[b];
            if (mem0[b + 1] > m) m = mem0[b + 1];
            if (mem0[b + 64] > m) m = mem0[b + 64];
            if (mem0[b + 65] > m) m = mem0[b + 65];
            exp_px[n] = ((m + 15) / 16) * 16;
        end
    endtask

    function automatic int unsigned exp_rd_addr(input int unsigned i);
        int unsigned n, k;
        n = i / 4;
        k = i % 4;
        return 2 * (n / 32) * 64 + 2 * (n % 32) + (k / 2) * 64 + (k % 2);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < int'(NRD); i++) mem0[i] = 13'($urandom_range(0, 4095));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {27'd0, busy, done, crd, cwr, csel}, 32'd0);
        check({tag, "_bus"}, {caddr_rd, caddr_wr}, 32'd0);
        check({tag, "_wdata"}, 32'(cdata_wr), 32'd0);
    endtask

    task automatic run_frame(input string tag, input bit repulse);
        int unsigned w0, r0, d0, b0, bb0, bc0, base, nw, nr, bad;
        bit seen;
        int unsigned exp8 [8];
        exp8 = '{0, 1, 64, 65, 2, 3, 66, 67};
        compute_ref();
        w0 = wr_addr_q.size();
        r0 = rd_addr_q.size();
        d0 = done_edge_q.size();
        b0 = busy_cycles;
        bb0 = bad_both;
        bc0 = bad_csel;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = edge_no;
        if (repulse) begin
            repeat (100) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 7000 && !seen; i++) begin
            @(negedge clk);
            if (done_edge_q.size() > d0) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);

        nw = wr_addr_q.size() - w0;
        nr = rd_addr_q.size() - r0;
        check({tag, "_wr_count"}, nw, NPIX);
        check({tag, "_rd_count"}, nr, NRD);
        check({tag, "_done_count"}, done_edge_q.size() - d0, 32'd1);
        check({tag, "_busy_cycles"}, busy_cycles - b0, 32'd6144);
        check({tag, "_rd_wr_overlap"}, bad_both - bb0, 32'd0);
        check({tag, "_csel"}, bad_csel - bc0, 32'd0);
        if (seen) check({tag, "_done_edge"}, done_edge_q[d0] - base, 32'd6145);

        if (nw == NPIX) begin
            check({tag, "_first_wr_edge"}, wr_edge_q[w0] - base, 32'd6);
            check({tag, "_last_wr_edge"}, wr_edge_q[w0 + NPIX - 1] - base, 32'd6144);
            bad = 0;
            for (int i = 0; i < int'(NPIX); i++)
                if (wr_addr_q[w0 + i] != i) bad++;
            check({tag, "_wr_addr_mismatches"}, bad, 32'd0);
            bad = 0;
            for (int i = 0; i < int'(NPIX); i++) begin
                got_px[i] = wr_data_q[w0 + i];
                if (got_px[i] != exp_px[i]) bad++;
            end
            check({tag, "_wr_data_mismatches"}, bad, 32'd0);
        end
        if (nr == NRD) begin
            check({tag, "_first_rd_edge"}, rd_edge_q[r0] - base, 32'd1);
            for (int k = 0; k < 8; k++)
                check($sformatf("%s_rd%0d", tag, k), rd_addr_q[r0 + k], exp8[k]);
            bad = 0;
            for (int i = 0; i < int'(NRD); i++)
                if (rd_addr_q[r0 + i] != exp_rd_addr(i)) bad++;
            check({tag, "_rd_addr_mismatches"}, bad, 32'd0);
            check({tag, "_row1_reads"},
                  {rd_addr_q[r0 + 128][7:0], rd_addr_q[r0 + 129][7:0],
                   rd_addr_q[r0 + 130][7:0], rd_addr_q[r0 + 131][7:0]},
                  {8'd128, 8'd129, 8'd192, 8'd193});
            if (nw == NPIX)
                check({tag, "_row1_wr_latency"},
                      wr_edge_q[w0 + 32] - rd_edge_q[r0 + 131], 32'd2);
        end
    endtask

    initial begin
        int unsigned r0, w0, b0, base;

        // Reset state, then idle with no start.
        repeat (3) @(negedge clk);
        check_outputs_zero("in_reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("idle_no_start");

        // Frame A: all-zero layer 0.
        for (int i = 0; i < int'(NRD); i++) mem0[i] = '0;
        run_frame("zero", 1'b0);
        check("zero_px0", got_px[0], 32'd0);

        // Frame B: random data plus directed windows, start re-pulsed mid-frame.
        fill_random();
        mem0[0] = 13'h0011; mem0[1] = 13'h0020; mem0[64] = 13'h001F; mem0[65] = 13'h0005;
        mem0[2] = 13'h0021; mem0[3] = 13'h0000; mem0[66] = 13'h0000; mem0[67] = 13'h0000;
        mem0[4030] = 13'h0FFF; mem0[4031] = 13'h0FFF;
        mem0[4094] = 13'h0FFF; mem0[4095] = 13'h0FFF;
        mem0[654] = 13'h0050; mem0[655] = 13'h0050; mem0[718] = 13'h0050; mem0[719] = 13'h0050;
        run_frame("rand", 1'b1);
        check("win00", got_px[0], 32'h20);
        check("win01", got_px[1], 32'h30);
        check("win_31_31", got_px[1023], 32'h1000);
        check("win_equal", got_px[5 * 32 + 7], 32'h50);

        // Frame C: reset dropped mid-frame, then a fresh full frame.
        fill_random();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = edge_no;
        while (edge_no - base < 3000) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        r0 = rd_addr_q.size();
        w0 = wr_addr_q.size();
        b0 = busy_cycles;
        repeat (30) @(negedge clk);
        check("post_reset_activity",
              (rd_addr_q.size() - r0) + (wr_addr_q.size() - w0) + (busy_cycles - b0), 32'd0);
        run_frame("rerun", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
